// File: rtl/relu_fifo.sv
// Elastic ReLU stage: per-lane ReLU at write, DEPTH-entry FWFT FIFO, frame-position tracking.
// Optional build macro RELU_FIFO_RELU_EN enables the ReLU; undefined gives a pure elastic buffer.
module relu_fifo #(
    parameter int DW        = 32,
    parameter int CH        = 2,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int FRAME_LEN = 93
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic             i_clr,
    input  logic [DW*CH-1:0] i_data,
    input  logic             i_stb_in,
    output logic             o_ack_in,
    output logic [DW*CH-1:0] o_data,
    output logic             o_stb_out,
    input  logic             i_ack_out,
    output logic             o_last,
    output logic             o_busy,
    output logic [AW:0]      o_level
);

    localparam int            FW        = $clog2(FRAME_LEN) + 1;
    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [FW-1:0] FCNT_LAST = FW'(FRAME_LEN - 1);

    typedef enum logic {ST_EMPTY, ST_FILL} state_t;

    state_t             state_q, state_d;
    logic [DW*CH-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        level_q, level_d;
    logic [FW-1:0]      fcnt_q, fcnt_d;
    logic               push, pop;
    logic [DW*CH-1:0]   wr_word;

    always_comb begin
        wr_word = i_data;
`ifdef RELU_FIFO_RELU_EN
        // A set sign bit clears the whole lane, so -0.0 is stored as +0.0 too.
        for (int k = 0; k < CH; k++) begin
            if (i_data[k*DW + DW-1]) wr_word[k*DW +: DW] = '0;
        end
`endif
    end

    assign o_ack_in  = (level_q != LVL_FULL) && !i_clr;
    assign o_stb_out = (level_q != '0);
    assign push      = i_stb_in && o_ack_in;
    assign pop       = o_stb_out && i_ack_out;
    assign o_data    = o_stb_out ? mem[rd_ptr_q] : '0;
    assign o_last    = o_stb_out && (fcnt_q == FCNT_LAST);
    assign o_busy    = (state_q == ST_FILL);
    assign o_level   = level_q;

    // NOTE: every next-state signal gets its default first, so no path through this block infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        fcnt_d   = fcnt_q;
        state_d  = state_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            fcnt_d   = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + 1'b1;
        end
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;
        case (state_q)
            ST_EMPTY: if (push) state_d = ST_FILL;
            ST_FILL:  if (pop && !push && level_q == (AW+1)'(1)) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!RSTn || i_clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            fcnt_q   <= '0;
            state_q  <= ST_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            fcnt_q   <= fcnt_d;
            state_q  <= state_d;
        end
    end

    // NOTE: storage is deliberately not reset; the empty-forces-zero mux on o_data hides stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_word;
    end

endmodule

// File: tb/tb_relu_fifo.sv
// Self-checking bench for relu_fifo: queue scoreboard plus directed handshake, wrap, frame and flush steps.
module tb_relu_fifo;

    localparam int DW = 32, CH = 2, DEPTH = 16, AW = 4, FL = 3;
    localparam int W = DW * CH;

    logic          clk = 1'b0;
    logic          RSTn = 1'b0;
    logic          i_clr = 1'b0;
    logic [W-1:0]  i_data = '0;
    logic          i_stb_in = 1'b0;
    logic          o_ack_in;
    logic [W-1:0]  o_data;
    logic          o_stb_out;
    logic          i_ack_out = 1'b0;
    logic          o_last;
    logic          o_busy;
    logic [AW:0]   o_level;

    relu_fifo #(.DW(DW), .CH(CH), .DEPTH(DEPTH), .AW(AW), .FRAME_LEN(FL)) dut (
        .clk(clk), .RSTn(RSTn), .i_clr(i_clr), .i_data(i_data), .i_stb_in(i_stb_in),
        .o_ack_in(o_ack_in), .o_data(o_data), .o_stb_out(o_stb_out), .i_ack_out(i_ack_out),
        .o_last(o_last), .o_busy(o_busy), .o_level(o_level)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] sb [$];
    int           fcnt_m = 0;
    logic         last_obs;
    logic [6:0]   last_mask;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] relu_m(input logic [W-1:0] w);
        logic [W-1:0] r;
        r = w;
`ifdef RELU_FIFO_RELU_EN
        for (int k = 0; k < CH; k++) if (w[k*DW + DW-1]) r[k*DW +: DW] = '0;
`endif
        return r;
    endfunction

    function automatic logic [W-1:0] mk(input int n);
        logic [DW-1:0] hi, lo;
        hi = DW'(n * 7) | ((n % 2 == 1) ? 32'h8000_0000 : 32'h0);
        lo = (32'h4000_0000 + DW'(n)) | ((n % 3 == 0) ? 32'h8000_0000 : 32'h0);
        return {hi, lo};
    endfunction

    // One clock: drive at negedge, compare all outputs against the model, then update the model at posedge.
    task automatic cycle(input logic stb, input logic [W-1:0] d, input logic ack, input logic clr);
        logic         exp_ack, exp_stb, push_m, pop_m;
        logic [W-1:0] exp_d;
        i_stb_in  = stb;
        i_data    = d;
        i_ack_out = ack;
        i_clr     = clr;
        #1;
        exp_ack = (sb.size() != DEPTH) && !clr;
        exp_stb = (sb.size() != 0);
        exp_d   = '0;
        if (exp_stb) exp_d = sb[0];
        check("ack_in",  64'(o_ack_in),  64'(exp_ack));
        check("stb_out", 64'(o_stb_out), 64'(exp_stb));
        check("level",   64'(o_level),   64'(sb.size()));
        check("busy",    64'(o_busy),    64'(exp_stb));
        check("data",    64'(o_data),    64'(exp_d));
        check("last",    64'(o_last),    64'(exp_stb && fcnt_m == FL-1));
        last_obs = o_last;
        push_m = stb && exp_ack;
        pop_m  = exp_stb && ack;
        @(posedge clk);
        if (clr) begin
            sb.delete();
            fcnt_m = 0;
        end else begin
            if (pop_m) begin
                void'(sb.pop_front());
                fcnt_m = (fcnt_m == FL-1) ? 0 : fcnt_m + 1;
            end
            if (push_m) sb.push_back(relu_m(d));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        i_stb_in = 1'b0; i_ack_out = 1'b0; i_clr = 1'b0; i_data = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        RSTn = 1'b1;
        sb.delete();
        fcnt_m = 0;
    endtask

    initial begin
        logic [W-1:0] t2_in, t2_exp;
        do_reset();

        // Reset state, idle inputs.
        check("rst_ack",   64'(o_ack_in),  64'(1));
        check("rst_stb",   64'(o_stb_out), 64'(0));
        check("rst_level", 64'(o_level),   64'(0));
        check("rst_busy",  64'(o_busy),    64'(0));
        check("rst_data",  64'(o_data),    64'(0));
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Single word with a negative lane; visible the cycle after the push.
        t2_in = {32'hBF80_0000, 32'h4000_0000};
`ifdef RELU_FIFO_RELU_EN
        t2_exp = {32'h0000_0000, 32'h4000_0000};
`else
        t2_exp = {32'hBF80_0000, 32'h4000_0000};
`endif
        cycle(1'b1, t2_in, 1'b1, 1'b0);
        check("t2_data", 64'(o_data),    64'(t2_exp));
        check("t2_stb",  64'(o_stb_out), 64'(1));
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("t2_empty", 64'(o_stb_out), 64'(0));

        // Fill with 17 offered words, 16 accepted; then drain in order.
        for (int i = 0; i < 17; i++) cycle(1'b1, mk(i), 1'b0, 1'b0);
        check("t3_full_level", 64'(o_level),  64'(16));
        check("t3_full_ack",   64'(o_ack_in), 64'(0));
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("t3_drain_level", 64'(o_level),   64'(0));
        check("t3_drain_stb",   64'(o_stb_out), 64'(0));

        // From full, simultaneous offer and drain for 32 cycles: overlap across pointer wrap.
        for (int i = 0; i < 16; i++) cycle(1'b1, mk(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, mk(200 + i), 1'b1, 1'b0);
            check("t4_level", 64'(o_level), 64'(15));
        end
        for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Frame marker: after a flush, 7 pops flag pops 3 and 6.
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b1, mk(300 + i), 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            last_mask[i] = last_obs;
        end
        check("t5_last_mask", 64'(last_mask), 64'(7'b010_0100));

        // Flush at level 5 / frame position 2 drops the offered word and restarts the frame.
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b1, mk(400 + i), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("t6_pre_level", 64'(o_level), 64'(5));
        check("t6_pre_last",  64'(o_last),  64'(1));
        cycle(1'b1, mk(999), 1'b1, 1'b1);
        check("t6_level", 64'(o_level),   64'(0));
        check("t6_stb",   64'(o_stb_out), 64'(0));
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(500 + i), 1'b0, 1'b0);
        check("t6_first_last", 64'(o_last), 64'(0));
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Reset mid-operation discards buffered words and frame position.
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(600 + i), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        do_reset();
        check("mid_rst_level", 64'(o_level), 64'(0));
        check("mid_rst_data",  64'(o_data),  64'(0));
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(700 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
